// File: rtl/clken_sched_if.sv
// Config request channel for clken_sched.
// Master drives a channel/divisor/enable request; slave answers with ready.
interface clken_sched_if #(
  parameter int CHW  = 2,
  parameter int DIVW = 8
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  logic [DIVW-1:0] cfg_div;
  logic            cfg_en;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/clken_sched.sv
// Multi-channel clock-enable scheduler.
// Per-channel programmable period with boundary-aligned divisor updates.
module clken_sched #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int DIVW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sync_start,
  clken_sched_if.slave   cfg,
  output logic [NCH-1:0] ce,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] pend
);

  logic [NCH-1:0]  en_q, en_d;
  logic [NCH-1:0]  pv_q, pv_d;
  logic [NCH-1:0]  ce_q, ce_d;
  logic [DIVW-1:0] cnt_q [NCH];
  logic [DIVW-1:0] cnt_d [NCH];
  logic [DIVW-1:0] div_q [NCH];
  logic [DIVW-1:0] div_d [NCH];
  logic [DIVW-1:0] pdiv_q [NCH];
  logic [DIVW-1:0] pdiv_d [NCH];
  logic [DIVW-1:0] dn;
  logic            acc;

  assign cfg.cfg_ready = ~sync_start & ~pv_q[cfg.cfg_ch];
  assign acc = cfg.cfg_valid & cfg.cfg_ready;
  assign dn  = (cfg.cfg_div == '0) ? DIVW'(1) : cfg.cfg_div;

  always_comb begin
    en_d = en_q;
    pv_d = pv_q;
    ce_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (en_q[i]) begin
        if (cnt_q[i] == DIVW'(div_q[i] - 1'b1)) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
          if (pv_q[i]) begin
            div_d[i] = pdiv_q[i];
            pv_d[i]  = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
      if (acc && cfg.cfg_ch == CHW'(i)) begin
        if (!cfg.cfg_en) begin
          en_d[i]  = 1'b0;
          cnt_d[i] = '0;
          pv_d[i]  = 1'b0;
          ce_d[i]  = 1'b0;
        end else if (!en_q[i]) begin
          en_d[i]  = 1'b1;
          div_d[i] = dn;
          cnt_d[i] = '0;
          pv_d[i]  = 1'b0;
        end else begin
          pdiv_d[i] = dn;
          pv_d[i]   = 1'b1;
        end
      end
      // realign: restart the period, folding in any pending divisor
      if (sync_start && en_q[i]) begin
        cnt_d[i] = '0;
        ce_d[i]  = 1'b0;
        if (pv_q[i]) begin
          div_d[i] = pdiv_q[i];
          pv_d[i]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= '0;
      pv_q <= '0;
      ce_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= '0;
        pdiv_q[i] <= '0;
      end
    end else begin
      en_q <= en_d;
      pv_q <= pv_d;
      ce_q <= ce_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
    end
  end

  assign ce     = ce_q;
  assign active = en_q;
  assign pend   = pv_q;

endmodule

// File: tb/tb_clken_sched.sv
// Directed bench for clken_sched.
// Expected pulse positions are hand-derived edge by edge.
module tb_clken_sched;

  logic       clk;
  logic       rst_n;
  logic       sync_start;
  logic [3:0] ce;
  logic [3:0] active;
  logic [3:0] pend;
  int         total;
  int         bad;

  clken_sched_if #(.CHW(2), .DIVW(8)) cif ();

  clken_sched #(.NCH(4), .CHW(2), .DIVW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_start (sync_start),
    .cfg        (cif),
    .ce         (ce),
    .active     (active),
    .pend       (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] dv,
                        input logic en);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch    = ch;
    cif.cfg_div   = dv;
    cif.cfg_en    = en;
    step();
    cif.cfg_valid = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    sync_start    = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_ch    = '0;
    cif.cfg_div   = '0;
    cif.cfg_en    = 1'b0;
    step();
    step();
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    rst_n = 1'b1;
    step();

    // ch0 period 5: pulses 5, 10, 15 edges after the accept
    do_cfg(2'd0, 8'd5, 1'b1);
    chk("en0_active", 32'(active), 32'h1);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk($sformatf("div5_e%0d", n), 32'(ce),
          (n % 5 == 0) ? 32'h1 : 32'h0);
    end

    // ch1 div 1, ch2 div 0 -> continuous; ch0 cnt 1,2,3,4,wrap
    do_cfg(2'd1, 8'd1, 1'b1);
    do_cfg(2'd2, 8'd0, 1'b1);
    chk("ch1_first", 32'(ce), 32'h2);
    step();
    chk("cont_a", 32'(ce), 32'h6);
    step();
    chk("cont_b", 32'(ce), 32'h6);
    step();
    chk("cont_wrap0", 32'(ce), 32'h7);
    chk("act_0111", 32'(active), 32'h7);
    do_cfg(2'd1, 8'd0, 1'b0);
    chk("dis1_ce", 32'(ce), 32'h4);
    do_cfg(2'd2, 8'd0, 1'b0);
    chk("dis2_ce", 32'(ce), 32'h0);
    chk("dis2_act", 32'(active), 32'h1);

    // ch0 cnt=2 now; run to the wrap, then one more edge
    step();
    step();
    step();
    chk("pre_upd_pulse", 32'(ce), 32'h1);
    step();
    do_cfg(2'd0, 8'd3, 1'b1);
    chk("upd_pend", 32'(pend), 32'h1);
    cif.cfg_ch = 2'd0;
    #1;
    chk("rdy_ch0", 32'(cif.cfg_ready), 32'h0);
    cif.cfg_ch = 2'd1;
    #1;
    chk("rdy_ch1", 32'(cif.cfg_ready), 32'h1);
    for (int n = 1; n <= 9; n++) begin
      step();
      chk($sformatf("upd_e%0d", n), 32'(ce),
          (n == 3 || n == 6 || n == 9) ? 32'h1 : 32'h0);
      if (n == 2) chk("pend_hold", 32'(pend), 32'h1);
      if (n == 3) chk("pend_clr", 32'(pend), 32'h0);
    end

    // ch0 at 5 with update to 2 pending, then realign
    do_cfg(2'd0, 8'd0, 1'b0);
    do_cfg(2'd0, 8'd5, 1'b1);
    do_cfg(2'd0, 8'd2, 1'b1);
    chk("sync_pre_pend", 32'(pend), 32'h1);
    sync_start    = 1'b1;
    cif.cfg_valid = 1'b1;
    cif.cfg_ch    = 2'd1;
    cif.cfg_div   = 8'd7;
    cif.cfg_en    = 1'b1;
    #1;
    chk("sync_rdy", 32'(cif.cfg_ready), 32'h0);
    step();
    sync_start    = 1'b0;
    cif.cfg_valid = 1'b0;
    chk("sync_ce", 32'(ce), 32'h0);
    chk("sync_pend", 32'(pend), 32'h0);
    chk("sync_act", 32'(active), 32'h1);
    for (int n = 1; n <= 4; n++) begin
      step();
      chk($sformatf("sync_e%0d", n), 32'(ce),
          (n % 2 == 0) ? 32'h1 : 32'h0);
    end

    // disable at cnt=4 suppresses the pulse; re-enable at 4
    do_cfg(2'd0, 8'd0, 1'b0);
    do_cfg(2'd0, 8'd5, 1'b1);
    step();
    step();
    step();
    step();
    do_cfg(2'd0, 8'd0, 1'b0);
    chk("dis4_ce", 32'(ce), 32'h0);
    chk("dis4_act", 32'(active), 32'h0);
    do_cfg(2'd0, 8'd4, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      step();
      chk($sformatf("reen_e%0d", n), 32'(ce),
          (n == 4) ? 32'h1 : 32'h0);
    end

    // reset mid-run with a pending update
    do_cfg(2'd0, 8'd0, 1'b0);
    do_cfg(2'd0, 8'd5, 1'b1);
    do_cfg(2'd0, 8'd2, 1'b1);
    chk("prerst_pend", 32'(pend), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_ce", 32'(ce), 32'h0);
    chk("mrst_act", 32'(active), 32'h0);
    chk("mrst_pend", 32'(pend), 32'h0);
    for (int n = 1; n <= 10; n++) begin
      step();
      chk($sformatf("post_rst_e%0d", n), 32'(ce), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clken_sched.md
Name: clken_sched

Overview:
- Multi-channel clock-enable scheduler: one registered single-cycle ce pulse train per channel, each at its own programmable period.
- Replaces per-module hard-coded divide-by-N enable generators. Downstream counters run on clk gated by ce[i].
- Divisors and enables are reconfigured at runtime through a valid/ready config port. Divisor changes on a running channel apply glitch-free at the period boundary.

Parameters:
NCH, 4, number of enable channels (2..8)
CHW, 2, channel index width, must equal clog2(NCH)
DIVW, 8, divisor width; period range 1..2^DIVW-1 cycles

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cfg_valid  in  1  config request valid
cfg_ready  out  1  config accept (combinational)
cfg_ch  in  CHW  target channel
cfg_div  in  DIVW  requested period in cycles; 0 treated as 1
cfg_en  in  1  1 = enable/update channel, 0 = disable channel
sync_start  in  1  realign all channels, one cycle
ce  out  NCH  registered enable pulses
active  out  NCH  channel enabled flags
pend  out  NCH  divisor update pending flags

Behaviour:
- Per-channel state: en, cnt[DIVW-1:0], div[DIVW-1:0], pdiv[DIVW-1:0], pv (pending valid).
- Reset (rst_n=0 at a clk edge): all en, cnt, div, pv and ce cleared to 0; active=0, pend=0. Reset mid-operation aborts pulses and pending updates immediately.
- cfg_ready = ~sync_start & ~pv[cfg_ch]. An accept is cfg_valid & cfg_ready at a rising edge. cfg_ready may be sampled without cfg_valid.
- Divisor normalisation: Dn = (cfg_div==0) ? 1 : cfg_div.
- Accept with cfg_en=1 on a disabled channel: en<=1, div<=Dn, cnt<=0, pv<=0.
- Accept with cfg_en=1 on an enabled channel: pdiv<=Dn, pv<=1. The channel keeps its current period.
- Accept with cfg_en=0: en<=0, cnt<=0, pv<=0, and ce[ch]<=0 at the same edge. This applies whether or not the channel is enabled.
- Enabled channel counting, every edge:
  - If cnt==div-1 (wrap): cnt<=0 and ce[i]<=1. If pv, also div<=pdiv and pv<=0.
  - Otherwise: cnt<=cnt+1 and ce[i]<=0.
- Disabled channel: cnt holds 0, ce[i]<=0.
- Timing from an enable accept at edge k with period D: ce[i] goes high after edge k+D, stays high one cycle, then repeats every D cycles. With D=1, ce[i] is held high continuously from edge k+1.
- Pending update timing: the last pulse at the old period occurs at the wrap edge. The first pulse at the new period follows new-D cycles later.
- sync_start at an edge: every enabled channel gets cnt<=0 and ce<=0. Any pending divisor is applied immediately (div<=pdiv, pv<=0). Disabled channels are unaffected. cfg is not accepted in that cycle.
- Priority at an edge: rst_n > sync_start > cfg accept > counting.
- A cfg accept on channel j does not disturb the counters of other channels.
- active = en vector; pend = pv vector; both registered.
- Widths: cnt compare is done in DIVW bits. div is never 0 internally.

Test Plan:
- Reset, then enable ch0 with cfg_div=5 at edge k -> ce[0] pulses after edges k+5, k+10, k+15 (1 cycle high, 4 low); ce[3:1]=0; active=4'b0001.
- Enable ch1 with div=1 and ch2 with div=0 -> ce[1] and ce[2] held high every cycle; active=4'b0111.
- ch0 running at 5; update to div=3 at edge where cnt=1 -> pend[0]=1; cfg_ready=0 for cfg_ch=0, 1 for other channels; pulse at old spacing 5 at the wrap; next pulses 3 apart; pend[0] clears at the wrap edge.
- ch0 at 5 with update to 2 pending, then sync_start -> ce=0 after that edge, pend=0; ch0 next pulse 2 cycles later; cfg_valid during sync sees cfg_ready=0.
- Disable ch0 (cfg_en=0) in the cycle where cnt=4 -> no pulse issued; active[0]=0; re-enable with div=4 -> first pulse 4 cycles after the accept.
- Assert rst_n=0 for one edge while ch0 runs at 5 with an update pending -> ce, active and pend all 0 next cycle; no pulses until reconfigured.
